// File: rtl/mem_io_if.sv
// Byte-wide CPU memory bus plus the UART-side FIFO handshakes and status flags
// seen by the memory/I/O responder.
interface mem_io_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    input  mem_din, rx_ready, tx_valid, tx_data, prog_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
    output mem_din, rx_ready, tx_valid, tx_data, prog_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: 128KB RAM, UART in/out FIFOs, cycle counter
// with coherent 32-bit snapshot, and program-stop flag in the 0x30000 I/O page.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int FIFO_AW    = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  mem_io_if.slave  bus
);

  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  typedef enum logic {SRC_IO, SRC_RAM} src_e;

  logic [7:0] ram     [RAM_DEPTH];
  logic [7:0] in_mem  [FIFO_DEPTH];
  logic [7:0] out_mem [FIFO_DEPTH];

  logic [FIFO_AW:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [31:0]      cycle_cnt, snapshot;
  logic [7:0]       ram_q, io_q, io_rdata;
  src_e             din_src;
  logic             prog_stop_q, tx_overflow_q;

  // Bus decode; everything bus-initiated is gated by rdy_in.
  logic        is_io, is_ram, is_rd, is_wr;
  logic [15:0] io_off;
  logic        unused_addr_bits;

  assign is_io  = rdy_in && (bus.mem_a[17:16] == 2'b11);
  assign is_ram = rdy_in && !bus.mem_a[17];
  assign is_rd  = !bus.mem_wr;
  assign is_wr  = bus.mem_wr;
  assign io_off = bus.mem_a[15:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];

  // FIFO status: equal index with differing wrap bit means full.
  logic in_empty, in_full, out_empty, out_full;
  assign in_empty  = (in_wr_ptr == in_rd_ptr);
  assign in_full   = (in_wr_ptr[FIFO_AW-1:0] == in_rd_ptr[FIFO_AW-1:0]) &&
                     (in_wr_ptr[FIFO_AW] != in_rd_ptr[FIFO_AW]);
  assign out_empty = (out_wr_ptr == out_rd_ptr);
  assign out_full  = (out_wr_ptr[FIFO_AW-1:0] == out_rd_ptr[FIFO_AW-1:0]) &&
                     (out_wr_ptr[FIFO_AW] != out_rd_ptr[FIFO_AW]);

  logic in_push, in_pop, out_req, out_push, out_pop, out_drop;
  assign in_push  = bus.rx_valid && !in_full;
  assign in_pop   = is_io && is_rd && (io_off == 16'h0000) && !in_empty;
  assign out_pop  = !out_empty && bus.tx_ready;
  assign out_req  = is_io && is_wr && (io_off == 16'h0000) && (bus.mem_dout != 8'h00);
  // A same-cycle pop frees the slot the push lands in, so only a stalled full FIFO drops.
  assign out_push = out_req && (!out_full || out_pop);
  assign out_drop = out_req && out_full && !out_pop;

  assign bus.rx_ready    = !in_full;
  assign bus.tx_valid    = !out_empty;
  assign bus.tx_data     = out_mem[out_rd_ptr[FIFO_AW-1:0]];
  assign bus.prog_stop   = prog_stop_q;
  assign bus.tx_overflow = tx_overflow_q;
  assign bus.mem_din     = (din_src == SRC_RAM) ? ram_q : io_q;

  always_comb begin
    // NOTE: default first so every path assigns io_rdata and no latch is inferred.
    io_rdata = 8'h00;
    if (is_io && is_rd) begin
      case (io_off)
        16'h0000: if (!in_empty) io_rdata = in_mem[in_rd_ptr[FIFO_AW-1:0]];
        16'h0004: io_rdata = cycle_cnt[7:0];
        16'h0005: io_rdata = snapshot[15:8];
        16'h0006: io_rdata = snapshot[23:16];
        16'h0007: io_rdata = snapshot[31:24];
        default:  io_rdata = 8'h00;
      endcase
    end
  end

  // NOTE: RAM and FIFO storage carry no reset; only pointers and control state do.
  always_ff @(posedge clk_in) begin
    if (is_ram && is_wr) ram[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
    if (is_ram && is_rd) ram_q <= ram[bus.mem_a[RAM_ADDR_W-1:0]];
    if (in_push)  in_mem[in_wr_ptr[FIFO_AW-1:0]]   <= bus.rx_data;
    if (out_push) out_mem[out_wr_ptr[FIFO_AW-1:0]] <= bus.mem_dout;
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_wr_ptr     <= '0;
      in_rd_ptr     <= '0;
      out_wr_ptr    <= '0;
      out_rd_ptr    <= '0;
      cycle_cnt     <= '0;
      snapshot      <= '0;
      io_q          <= 8'h00;
      din_src       <= SRC_IO;
      prog_stop_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (rdy_in)   cycle_cnt  <= cycle_cnt + 32'd1;
      if (in_push)  in_wr_ptr  <= in_wr_ptr + 1'b1;
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + 1'b1;
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      if (out_drop) tx_overflow_q <= 1'b1;

      // Reads retarget mem_din; writes and frozen cycles leave it untouched.
      if (rdy_in && is_rd) begin
        din_src <= is_ram ? SRC_RAM : SRC_IO;
        io_q    <= io_rdata;
      end
      if (is_io && is_rd && io_off == 16'h0004) snapshot    <= cycle_cnt;
      if (is_io && is_wr && io_off == 16'h0004) prog_stop_q <= 1'b1;
    end
  end

endmodule
